hack_vector_checker: RTL and testbench



---
 rtl/hack_vector_checker_if.sv | 51 +++++
 rtl/hack_vector_checker.sv | 161 ++++++++++++++++
 tb/tb_hack_vector_checker.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_vector_checker_if.sv
// Bus bundle between the vector checker and its host: vector loading, run control,
// the CPU drive/response pair and the run status.
interface hack_vector_checker_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int IDX_W  = 6
);
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_instr;
  logic [DATA_W-1:0] ld_inm;
  logic              ld_cpu_rst;
  logic [DATA_W-1:0] ld_exp_outm;
  logic [ADDR_W-1:0] ld_exp_addr;
  logic [ADDR_W-1:0] ld_exp_pc;
  logic              ld_exp_wr;
  logic [3:0]        ld_mask;
  logic [IDX_W:0]    num_vec;
  logic              start;

  logic [DATA_W-1:0] cpu_instruction;
  logic [DATA_W-1:0] cpu_inM;
  logic              cpu_rst;
  logic [DATA_W-1:0] cpu_outM;
  logic [ADDR_W-1:0] cpu_addressM;
  logic [ADDR_W-1:0] cpu_pc;
  logic              cpu_writeM;

  logic              busy;
  logic              done;
  logic              pass;
  logic              mismatch;
  logic [IDX_W:0]    err_count;
  logic [IDX_W-1:0]  first_err_idx;

  modport master (
    output ld_en, ld_idx, ld_instr, ld_inm, ld_cpu_rst, ld_exp_outm, ld_exp_addr,
           ld_exp_pc, ld_exp_wr, ld_mask, num_vec, start,
           cpu_outM, cpu_addressM, cpu_pc, cpu_writeM,
    input  cpu_instruction, cpu_inM, cpu_rst,
           busy, done, pass, mismatch, err_count, first_err_idx
  );

  modport slave (
    input  ld_en, ld_idx, ld_instr, ld_inm, ld_cpu_rst, ld_exp_outm, ld_exp_addr,
           ld_exp_pc, ld_exp_wr, ld_mask, num_vec, start,
           cpu_outM, cpu_addressM, cpu_pc, cpu_writeM,
    output cpu_instruction, cpu_inM, cpu_rst,
           busy, done, pass, mismatch, err_count, first_err_idx
  );
endinterface

// File: rtl/hack_vector_checker.sv
// Vector player for the CPU16 core: streams stored stimulus into the CPU one vector
// per clock and compares the CPU outputs against masked per-vector expectations.
module hack_vector_checker #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 15,
  parameter int DEPTH       = 64,
  parameter int IDX_W       = 6,
  parameter int STOP_ON_ERR = 0
) (
  input logic clk,
  input logic rst,
  hack_vector_checker_if.slave bus
);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] inm;
    logic              cpuRst;
    logic [DATA_W-1:0] expOutm;
    logic [ADDR_W-1:0] expAddr;
    logic [ADDR_W-1:0] expPc;
    logic              expWr;
    logic [3:0]        mask;
  } vec_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           stateReg, stateNext;
  logic [IDX_W-1:0] idxReg, idxNext;
  logic [IDX_W-1:0] firstReg, firstNext;
  logic [CNT_W-1:0] nReg, nNext;
  logic [CNT_W-1:0] errReg, errNext;
  logic [CNT_W-1:0] nClamp;
  logic             passReg, passNext;
  logic             misReg, misNext;

  vec_t mem [DEPTH];
  vec_t rdWord, ldWord, bypassWord, curWord;
  logic bypassReg;
  logic wrEn;
  logic running;

  logic [3:0] fieldDiff, fieldFail;
  logic       anyMis, isLast;

  assign ldWord = '{instr:   bus.ld_instr,
                    inm:     bus.ld_inm,
                    cpuRst:  bus.ld_cpu_rst,
                    expOutm: bus.ld_exp_outm,
                    expAddr: bus.ld_exp_addr,
                    expPc:   bus.ld_exp_pc,
                    expWr:   bus.ld_exp_wr,
                    mask:    bus.ld_mask};

  assign wrEn = bus.ld_en && !rst && (stateReg != RUN) && ({1'b0, bus.ld_idx} < CNT_W'(DEPTH));

  // Registered read of the slot that will be driven next cycle; a write landing on that
  // same slot in the start cycle is forwarded so the run sees the new data.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[bus.ld_idx] <= ldWord;
    end
    rdWord     <= mem[idxNext];
    bypassReg  <= wrEn && (bus.ld_idx == idxNext);
    bypassWord <= ldWord;
  end

  assign curWord = bypassReg ? bypassWord : rdWord;
  assign running = (stateReg == RUN);

  assign fieldDiff = {curWord.expPc   != bus.cpu_pc,
                      curWord.expAddr != bus.cpu_addressM,
                      curWord.expWr   != bus.cpu_writeM,
                      curWord.expOutm != bus.cpu_outM};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_field
      assign fieldFail[gi] = curWord.mask[gi] & fieldDiff[gi];
    end
  endgenerate

  assign anyMis = |fieldFail;
  assign isLast = (({1'b0, idxReg} + CNT_W'(1)) == nReg);
  assign nClamp = (bus.num_vec > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.num_vec;

  always_comb begin
    stateNext = stateReg;
    idxNext   = idxReg;
    firstNext = firstReg;
    nNext     = nReg;
    errNext   = errReg;
    passNext  = passReg;
    misNext   = 1'b0;
    case (stateReg)
      IDLE, DONE: begin
        if (bus.start) begin
          errNext   = '0;
          firstNext = '0;
          passNext  = 1'b0;
          idxNext   = '0;
          nNext     = nClamp;
          if (nClamp == '0) begin
            stateNext = DONE;
            passNext  = 1'b1;
          end else begin
            stateNext = RUN;
          end
        end
      end
      RUN: begin
        if (anyMis) begin
          errNext = errReg + CNT_W'(1);
          misNext = 1'b1;
          if (errReg == '0) begin
            firstNext = idxReg;
          end
        end
        if (isLast || ((STOP_ON_ERR != 0) && anyMis)) begin
          stateNext = DONE;
          passNext  = (errNext == '0);
        end else begin
          idxNext = idxReg + IDX_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      idxReg   <= '0;
      firstReg <= '0;
      nReg     <= '0;
      errReg   <= '0;
      passReg  <= 1'b0;
      misReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      idxReg   <= idxNext;
      firstReg <= firstNext;
      nReg     <= nNext;
      errReg   <= errNext;
      passReg  <= passNext;
      misReg   <= misNext;
    end
  end

  // Outside a run the CPU is parked in reset with a zero instruction bus.
  assign bus.cpu_instruction = running ? curWord.instr : '0;
  assign bus.cpu_inM         = running ? curWord.inm   : '0;
  assign bus.cpu_rst         = running ? curWord.cpuRst : 1'b1;

  assign bus.busy          = running;
  assign bus.done          = (stateReg == DONE);
  assign bus.pass          = passReg;
  assign bus.mismatch      = misReg;
  assign bus.err_count     = errReg;
  assign bus.first_err_idx = firstReg;
endmodule

// File: tb/tb_hack_vector_checker.sv
// Bench for hack_vector_checker: two instances (free-running and stop-on-error) share
// stimulus and are checked every cycle against a behavioural run model.
module tb_hack_vector_checker;
  localparam int DW = 16, AW = 15, DEPTH = 32, IW = 5, CW = IW + 1;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] inm;
    logic          cpuRst;
    logic [DW-1:0] expOutm;
    logic [AW-1:0] expAddr;
    logic [AW-1:0] expPc;
    logic          expWr;
    logic [3:0]    mask;
  } tv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          ldEn = 1'b0;
  logic [IW-1:0] ldIdx = '0;
  tv_t           ldVec = '0;
  logic [CW-1:0] numVec = '0;
  logic          start = 1'b0;
  logic [DW-1:0] cpuOutM = '0;
  logic [AW-1:0] cpuAddressM = '0;
  logic [AW-1:0] cpuPc = '0;
  logic          cpuWriteM = 1'b0;

  hack_vector_checker_if #(.DATA_W(DW), .ADDR_W(AW), .IDX_W(IW)) b0 ();
  hack_vector_checker_if #(.DATA_W(DW), .ADDR_W(AW), .IDX_W(IW)) b1 ();

  assign b0.ld_en = ldEn, b1.ld_en = ldEn;
  assign b0.ld_idx = ldIdx, b1.ld_idx = ldIdx;
  assign b0.ld_instr = ldVec.instr, b1.ld_instr = ldVec.instr;
  assign b0.ld_inm = ldVec.inm, b1.ld_inm = ldVec.inm;
  assign b0.ld_cpu_rst = ldVec.cpuRst, b1.ld_cpu_rst = ldVec.cpuRst;
  assign b0.ld_exp_outm = ldVec.expOutm, b1.ld_exp_outm = ldVec.expOutm;
  assign b0.ld_exp_addr = ldVec.expAddr, b1.ld_exp_addr = ldVec.expAddr;
  assign b0.ld_exp_pc = ldVec.expPc, b1.ld_exp_pc = ldVec.expPc;
  assign b0.ld_exp_wr = ldVec.expWr, b1.ld_exp_wr = ldVec.expWr;
  assign b0.ld_mask = ldVec.mask, b1.ld_mask = ldVec.mask;
  assign b0.num_vec = numVec, b1.num_vec = numVec;
  assign b0.start = start, b1.start = start;
  assign b0.cpu_outM = cpuOutM, b1.cpu_outM = cpuOutM;
  assign b0.cpu_addressM = cpuAddressM, b1.cpu_addressM = cpuAddressM;
  assign b0.cpu_pc = cpuPc, b1.cpu_pc = cpuPc;
  assign b0.cpu_writeM = cpuWriteM, b1.cpu_writeM = cpuWriteM;

  hack_vector_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .IDX_W(IW), .STOP_ON_ERR(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  hack_vector_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .IDX_W(IW), .STOP_ON_ERR(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Behavioural model: per instance, a vector store plus run bookkeeping.
  tv_t mMem [2][DEPTH];
  int  mRun[2] = '{0, 0};
  int  mDone[2] = '{0, 0};
  int  mPass[2] = '{0, 0};
  int  mMis[2] = '{0, 0};
  int  mErr[2] = '{0, 0};
  int  mFirst[2] = '{0, 0};
  int  mIdx[2] = '{0, 0};
  int  mN[2] = '{0, 0};

  int nChecks = 0;
  int nFails = 0;
  bit checkOn = 1'b0;
  bit respDirected = 1'b0;
  int badK = -1;

  // Outputs of a correct CPU16 running the three-instruction test program.
  int dOut[3]  = '{0, 0, 12345};
  int dWr[3]   = '{0, 0, 1};
  int dAddr[3] = '{0, 12345, 12345};
  int dPc[3]   = '{0, 1, 2};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic stepModel(int m);
    tv_t v;
    bit  mis;
    int  n;
    if (rst) begin
      mRun[m] = 0; mDone[m] = 0; mPass[m] = 0; mMis[m] = 0;
      mErr[m] = 0; mFirst[m] = 0; mIdx[m] = 0;
      return;
    end
    if (mRun[m] != 0) begin
      v = mMem[m][mIdx[m]];
      mis = (v.mask[0] && cpuOutM != v.expOutm) || (v.mask[1] && cpuWriteM != v.expWr) ||
            (v.mask[2] && cpuAddressM != v.expAddr) || (v.mask[3] && cpuPc != v.expPc);
      mMis[m] = mis ? 1 : 0;
      if (mis) begin
        if (mErr[m] == 0) mFirst[m] = mIdx[m];
        mErr[m]++;
      end
      if (mIdx[m] == mN[m] - 1 || (m == 1 && mis)) begin
        mRun[m] = 0; mDone[m] = 1; mPass[m] = (mErr[m] == 0) ? 1 : 0;
      end else begin
        mIdx[m]++;
      end
    end else begin
      mMis[m] = 0;
      if (ldEn) mMem[m][ldIdx] = ldVec;
      if (start) begin
        n = (int'(numVec) > DEPTH) ? DEPTH : int'(numVec);
        mErr[m] = 0; mFirst[m] = 0; mPass[m] = 0; mDone[m] = 0; mIdx[m] = 0; mN[m] = n;
        if (n == 0) begin
          mDone[m] = 1; mPass[m] = 1;
        end else begin
          mRun[m] = 1;
        end
      end
    end
  endtask

  task automatic cmpInst(int m, logic busy, logic done, logic pass, logic mism,
                         logic [CW-1:0] err, logic [IW-1:0] first, logic crst,
                         logic [DW-1:0] instr, logic [DW-1:0] inm);
    tv_t v;
    v = mMem[m][mIdx[m]];
    chk($sformatf("busy%0d", m), busy, mRun[m]);
    chk($sformatf("done%0d", m), done, mDone[m]);
    chk($sformatf("pass%0d", m), pass, mPass[m]);
    chk($sformatf("mismatch%0d", m), mism, mMis[m]);
    chk($sformatf("err_count%0d", m), err, mErr[m]);
    chk($sformatf("first_err_idx%0d", m), first, mFirst[m]);
    chk($sformatf("cpu_rst%0d", m), crst, (mRun[m] != 0) ? v.cpuRst : 1'b1);
    chk($sformatf("cpu_instruction%0d", m), instr, (mRun[m] != 0) ? v.instr : '0);
    chk($sformatf("cpu_inM%0d", m), inm, (mRun[m] != 0) ? v.inm : '0);
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      cmpInst(0, b0.busy, b0.done, b0.pass, b0.mismatch, b0.err_count, b0.first_err_idx,
              b0.cpu_rst, b0.cpu_instruction, b0.cpu_inM);
      cmpInst(1, b1.busy, b1.done, b1.pass, b1.mismatch, b1.err_count, b1.first_err_idx,
              b1.cpu_rst, b1.cpu_instruction, b1.cpu_inM);
    end
  end

  // One clock: choose the CPU response for the vector instance 0 is driving, then
  // advance the model on the edge and return at the following falling edge.
  task automatic tick();
    int  k;
    tv_t v;
    if (respDirected) begin
      k = (mRun[0] != 0 && mIdx[0] < 3) ? mIdx[0] : 0;
      cpuOutM = DW'(dOut[k]);
      cpuWriteM = dWr[k][0];
      cpuAddressM = AW'(dAddr[k]);
      cpuPc = AW'(dPc[k]);
      if (k == badK && mRun[0] != 0) cpuPc = cpuPc ^ AW'(1);
    end else if (mRun[0] != 0) begin
      v = mMem[0][mIdx[0]];
      cpuOutM = ($urandom_range(0, 31) == 0) ? DW'($urandom) : v.expOutm;
      cpuWriteM = ($urandom_range(0, 31) == 0) ? ~v.expWr : v.expWr;
      cpuAddressM = ($urandom_range(0, 31) == 0) ? AW'($urandom) : v.expAddr;
      cpuPc = ($urandom_range(0, 31) == 0) ? AW'($urandom) : v.expPc;
    end else begin
      cpuOutM = DW'($urandom); cpuWriteM = 1'($urandom);
      cpuAddressM = AW'($urandom); cpuPc = AW'($urandom);
    end
    @(posedge clk);
    stepModel(0);
    stepModel(1);
    @(negedge clk);
  endtask

  function automatic tv_t randVec();
    tv_t v;
    v.instr = DW'($urandom); v.inm = DW'($urandom); v.cpuRst = 1'($urandom);
    v.expOutm = DW'($urandom); v.expAddr = AW'($urandom); v.expPc = AW'($urandom);
    v.expWr = 1'($urandom); v.mask = 4'($urandom);
    return v;
  endfunction

  function automatic tv_t mkVec(int instr, int outm, int addr, int pc, int wr, int mask);
    tv_t v;
    v.instr = DW'(instr); v.inm = '0; v.cpuRst = 1'b0;
    v.expOutm = DW'(outm); v.expAddr = AW'(addr); v.expPc = AW'(pc);
    v.expWr = wr[0]; v.mask = 4'(mask);
    return v;
  endfunction

  task automatic load(int idx, tv_t v);
    ldIdx = IW'(idx); ldVec = v; ldEn = 1'b1;
    tick();
    ldEn = 1'b0;
  endtask

  task automatic startRun(int n);
    numVec = CW'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  tv_t v0, v1, v2, v1bad, v2bad, v2mask;

  initial begin
    v0     = mkVec(16'h3039, 0, 0, 0, 0, 4'b1110);
    v1     = mkVec(16'hEC10, 0, 12345, 1, 0, 4'b1110);
    v2     = mkVec(16'hE308, 12345, 12345, 2, 1, 4'b1111);
    v1bad  = mkVec(16'hEC10, 0, 0, 1, 0, 4'b1110);
    v2bad  = mkVec(16'hE308, 12344, 12345, 2, 1, 4'b1111);
    v2mask = mkVec(16'hE308, 12344, 12345, 2, 1, 4'b1110);

    tick();
    checkOn = 1'b1;
    tick();
    chk("reset_busy", b0.busy, 0);
    chk("reset_done", b0.done, 0);
    chk("reset_pass", b0.pass, 0);
    chk("reset_cpu_rst", b0.cpu_rst, 1);
    chk("reset_instr", b0.cpu_instruction, 0);
    chk("reset_err", b0.err_count, 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) load(i, randVec());

    // Clean run; v2 is written in the same cycle as start.
    respDirected = 1'b1;
    load(0, v0);
    load(1, v1);
    ldIdx = IW'(2); ldVec = v2; ldEn = 1'b1;
    startRun(3);
    ldEn = 1'b0;
    chk("clean_instr_v0", b0.cpu_instruction, 16'h3039);
    tick(); tick();
    chk("clean_busy_e2", b0.busy, 1);
    chk("clean_instr_v2", b0.cpu_instruction, 16'hE308);
    tick();
    chk("clean_done_e3", b0.done, 1);
    chk("clean_pass", b0.pass, 1);
    chk("clean_err", b0.err_count, 0);
    chk("clean_pass_stop", b1.pass, 1);

    // Bad expected outM on the last vector.
    load(2, v2bad);
    startRun(3);
    tick(); tick(); tick();
    chk("err_count", b0.err_count, 1);
    chk("err_first", b0.first_err_idx, 2);
    chk("err_pass", b0.pass, 0);
    chk("err_mismatch_e3", b0.mismatch, 1);
    tick();
    chk("err_mismatch_e4", b0.mismatch, 0);

    // Same bad value with outM masked off.
    load(2, v2mask);
    startRun(3);
    tick(); tick(); tick();
    chk("mask_pass", b0.pass, 1);
    chk("mask_err", b0.err_count, 0);

    // Failing v1: stop-on-error instance ends at E2.
    load(2, v2);
    load(1, v1bad);
    startRun(3);
    tick(); tick();
    chk("stop_done_e2", b1.done, 1);
    chk("stop_err", b1.err_count, 1);
    chk("stop_first", b1.first_err_idx, 1);
    chk("stop_cpu_rst", b1.cpu_rst, 1);
    chk("nostop_busy_e2", b0.busy, 1);
    tick();
    chk("nostop_done_e3", b0.done, 1);
    chk("nostop_pass", b0.pass, 0);

    // Empty run.
    startRun(0);
    chk("zero_done", b0.done, 1);
    chk("zero_pass", b0.pass, 1);
    chk("zero_busy", b0.busy, 0);

    // Reset in the middle of a run that has already failed once.
    load(1, v1);
    badK = 0;
    startRun(3);
    tick();
    chk("midrst_err_before", b0.err_count, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    badK = -1;
    chk("midrst_busy", b0.busy, 0);
    chk("midrst_err", b0.err_count, 0);
    chk("midrst_cpu_rst", b0.cpu_rst, 1);
    startRun(3);
    tick(); tick(); tick();
    chk("rerun_pass", b0.pass, 1);

    // start pulsed mid-run must not restart it.
    startRun(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("midstart_done_e3", b0.done, 1);
    chk("midstart_pass", b0.pass, 1);

    // Random traffic: loads, starts (with clamped lengths) and resets at any time.
    respDirected = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      ldEn = ($urandom_range(0, 2) == 0);
      ldIdx = IW'($urandom);
      ldVec = randVec();
      numVec = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 6));
      start = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    ldEn = 1'b0; start = 1'b0; rst = 1'b0;
    for (int c = 0; c < 40; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
